// File: rtl/ap_ctrl_perf_monitor.sv
// Passive multi-channel ap_ctrl_hs profiler: per-channel count, latency and II statistics,
// overrun/orphan/hang flags, and a registered one-cycle readout port.
module ap_ctrl_perf_monitor #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int MAX_OUT = 4,
  parameter int HANG_TO = 1024,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  input  logic              rd_en,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] overflow,
  output logic [NUM_CH-1:0] underflow,
  output logic [NUM_CH-1:0] hang,
  output logic              all_idle,
  output logic              frozen
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int OCC_W = $clog2(MAX_OUT + 1);
  localparam int HT_W  = $clog2(HANG_TO + 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(MAX_OUT);
  localparam logic [HT_W-1:0]  HANG_LOAD = HT_W'(HANG_TO);
  localparam logic [CNT_W-1:0] ALL_ONES  = '1;

  logic [CNT_W-1:0] ts;
  logic [CNT_W-1:0] fifo_mem [NUM_CH][MAX_OUT];
  logic [PTR_W-1:0] wr_ptr   [NUM_CH];
  logic [PTR_W-1:0] rd_ptr   [NUM_CH];
  logic [OCC_W-1:0] occ      [NUM_CH];
  logic [OCC_W-1:0] occ_nxt  [NUM_CH];
  logic [CNT_W-1:0] cnt      [NUM_CH];
  logic [CNT_W-1:0] lat_min  [NUM_CH];
  logic [CNT_W-1:0] lat_max  [NUM_CH];
  logic [CNT_W-1:0] lat_sum  [NUM_CH];
  logic [CNT_W-1:0] ii_min   [NUM_CH];
  logic [CNT_W-1:0] ii_max   [NUM_CH];
  logic [CNT_W-1:0] last_acc [NUM_CH];
  logic [CNT_W-1:0] lat      [NUM_CH];
  logic [CNT_W-1:0] ii       [NUM_CH];
  logic [CNT_W:0]   sum_ext  [NUM_CH];
  logic [HT_W-1:0]  hang_tmr [NUM_CH];
  logic [NUM_CH-1:0] seen_acc;
  logic [NUM_CH-1:0] acc, cmp, bypass, do_pop, do_push, lat_upd, ovf_set, unf_set, tmr_load;
  logic run;
  logic idle_nxt;
  logic [CNT_W-1:0] sel_val;

  always_comb begin
    run      = !(finish || frozen);
    idle_nxt = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      acc[c]      = run && ap_start[c] && ap_ready[c];
      cmp[c]      = run && ap_done[c] && ap_continue[c];
      bypass[c]   = acc[c] && cmp[c] && (occ[c] == '0);
      do_pop[c]   = cmp[c] && (occ[c] != '0);
      // A full FIFO can still take a start when the head leaves in the same cycle.
      do_push[c]  = acc[c] && !bypass[c] && ((occ[c] != OCC_FULL) || do_pop[c]);
      lat_upd[c]  = bypass[c] || do_pop[c];
      ovf_set[c]  = acc[c] && (occ[c] == OCC_FULL) && !do_pop[c];
      unf_set[c]  = cmp[c] && (occ[c] == '0) && !acc[c];
      tmr_load[c] = cmp[c] || (occ[c] == '0);
      lat[c]      = bypass[c] ? '0 : ts - fifo_mem[c][rd_ptr[c]];
      ii[c]       = ts - last_acc[c];
      sum_ext[c]  = {1'b0, lat_sum[c]} + {1'b0, lat[c]};
      occ_nxt[c]  = occ[c] + OCC_W'(do_push[c]) - OCC_W'(do_pop[c]);
      if (occ_nxt[c] != '0) idle_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (do_push[c]) fifo_mem[c][wr_ptr[c]] <= ts;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts        <= '0;
      frozen    <= 1'b0;
      all_idle  <= 1'b1;
      overflow  <= '0;
      underflow <= '0;
      hang      <= '0;
      seen_acc  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]   <= '0;
        rd_ptr[c]   <= '0;
        occ[c]      <= '0;
        cnt[c]      <= '0;
        lat_min[c]  <= ALL_ONES;
        lat_max[c]  <= '0;
        lat_sum[c]  <= '0;
        ii_min[c]   <= ALL_ONES;
        ii_max[c]   <= '0;
        last_acc[c] <= '0;
        hang_tmr[c] <= HANG_LOAD;
      end
    end else begin
      ts       <= ts + CNT_W'(1);
      all_idle <= idle_nxt;
      if (finish) frozen <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        occ[c] <= occ_nxt[c];
        if (do_push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (do_pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        if (acc[c]) begin
          if (cnt[c] != ALL_ONES) cnt[c] <= cnt[c] + CNT_W'(1);
          last_acc[c] <= ts;
          seen_acc[c] <= 1'b1;
          if (seen_acc[c]) begin
            if (ii[c] < ii_min[c]) ii_min[c] <= ii[c];
            if (ii[c] > ii_max[c]) ii_max[c] <= ii[c];
          end
        end
        if (lat_upd[c]) begin
          if (lat[c] < lat_min[c]) lat_min[c] <= lat[c];
          if (lat[c] > lat_max[c]) lat_max[c] <= lat[c];
          lat_sum[c] <= sum_ext[c][CNT_W] ? ALL_ONES : sum_ext[c][CNT_W-1:0];
        end
        if (ovf_set[c]) overflow[c]  <= 1'b1;
        if (unf_set[c]) underflow[c] <= 1'b1;
        // Hang timer counts down while work is outstanding; it holds once frozen.
        if (run) begin
          if (tmr_load[c]) begin
            hang_tmr[c] <= HANG_LOAD;
          end else if (hang_tmr[c] != '0) begin
            hang_tmr[c] <= hang_tmr[c] - HT_W'(1);
            if (hang_tmr[c] == HT_W'(1)) hang[c] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    sel_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        case (rd_sel)
          3'd0: sel_val = cnt[c];
          3'd1: sel_val = lat_min[c];
          3'd2: sel_val = lat_max[c];
          3'd3: sel_val = lat_sum[c];
          3'd4: sel_val = ii_min[c];
          3'd5: sel_val = ii_max[c];
          3'd6: sel_val = CNT_W'(occ[c]);
          3'd7: sel_val = CNT_W'({hang[c], underflow[c], overflow[c]});
          default: sel_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= sel_val;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Randomized scoreboard bench for ap_ctrl_perf_monitor against a queue-based reference model.
module tb_ap_ctrl_perf_monitor;
  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 32;
  localparam int MAX_OUT = 4;
  localparam int HANG_TO = 64;
  localparam int CH_W    = 3;
  localparam longint unsigned SAT = 64'h0000_0000_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset, finish, rd_en;
  logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic [CH_W-1:0] rd_ch;
  logic [2:0] rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic rd_valid, all_idle, frozen;
  logic [NUM_CH-1:0] overflow, underflow, hang;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] v;
    int ch;
    int sel;
  } exp_t;
  exp_t sb_q[$];

  // reference model state
  logic [31:0] m_ts;
  logic [31:0] m_q [NUM_CH][$];
  longint unsigned m_cnt[NUM_CH], m_lmin[NUM_CH], m_lmax[NUM_CH], m_lsum[NUM_CH];
  longint unsigned m_iimin[NUM_CH], m_iimax[NUM_CH];
  logic [31:0] m_last[NUM_CH];
  bit m_seen[NUM_CH];
  int m_busy[NUM_CH];
  logic [NUM_CH-1:0] m_ovf, m_unf, m_hang;
  bit m_frozen, m_idle;

  ap_ctrl_perf_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT), .HANG_TO(HANG_TO)
  ) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .overflow(overflow), .underflow(underflow), .hang(hang),
    .all_idle(all_idle), .frozen(frozen)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic record_lat(int c, longint unsigned lat);
    if (lat < m_lmin[c]) m_lmin[c] = lat;
    if (lat > m_lmax[c]) m_lmax[c] = lat;
    m_lsum[c] = (m_lsum[c] + lat > SAT) ? SAT : m_lsum[c] + lat;
  endtask

  task automatic model_step();
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_q[c].delete();
        m_cnt[c] = 0; m_lmin[c] = SAT; m_lmax[c] = 0; m_lsum[c] = 0;
        m_iimin[c] = SAT; m_iimax[c] = 0; m_last[c] = 0; m_seen[c] = 0; m_busy[c] = 0;
      end
      m_ovf = '0; m_unf = '0; m_hang = '0;
      m_ts = 0; m_frozen = 0; m_idle = 1;
      return;
    end
    if (!m_frozen && !finish) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit a, d;
        logic [31:0] diff;
        a = ap_start[c] && ap_ready[c];
        d = ap_done[c] && ap_continue[c];
        if (d || m_q[c].size() == 0) m_busy[c] = 0;
        else begin
          m_busy[c]++;
          if (m_busy[c] >= HANG_TO) m_hang[c] = 1'b1;
        end
        if (a) begin
          if (m_cnt[c] < SAT) m_cnt[c]++;
          if (m_seen[c]) begin
            diff = m_ts - m_last[c];
            if (diff < m_iimin[c]) m_iimin[c] = diff;
            if (diff > m_iimax[c]) m_iimax[c] = diff;
          end
          m_last[c] = m_ts;
          m_seen[c] = 1;
        end
        if (a && d && m_q[c].size() == 0) begin
          record_lat(c, 0);
        end else begin
          if (d) begin
            if (m_q[c].size() > 0) begin
              diff = m_ts - m_q[c].pop_front();
              record_lat(c, diff);
            end else m_unf[c] = 1'b1;
          end
          if (a) begin
            if (m_q[c].size() < MAX_OUT) m_q[c].push_back(m_ts);
            else m_ovf[c] = 1'b1;
          end
        end
      end
    end
    if (finish) m_frozen = 1;
    m_idle = 1;
    for (int c = 0; c < NUM_CH; c++) if (m_q[c].size() != 0) m_idle = 0;
    m_ts = m_ts + 1;
  endtask

  function automatic logic [31:0] exp_stat(int ch, int sel);
    if (ch >= NUM_CH) return 32'd0;
    case (sel)
      0: return 32'(m_cnt[ch]);
      1: return 32'(m_lmin[ch]);
      2: return 32'(m_lmax[ch]);
      3: return 32'(m_lsum[ch]);
      4: return 32'(m_iimin[ch]);
      5: return 32'(m_iimax[ch]);
      6: return 32'(m_q[ch].size());
      7: return {29'd0, m_hang[ch], m_unf[ch], m_ovf[ch]};
      default: return 32'd0;
    endcase
  endfunction

  // one clock: expected readout captured from pre-edge model state, then model and DUT advance
  task automatic step();
    exp_t e;
    bit req;
    req   = rd_en && !reset;
    e.ch  = int'(rd_ch);
    e.sel = int'(rd_sel);
    e.v   = exp_stat(e.ch, e.sel);
    model_step();
    @(posedge clock);
    if (req) sb_q.push_back(e);
    #1;
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("hang",      32'(hang),      32'(m_hang));
    chk("all_idle",  32'(all_idle),  32'(m_idle));
    chk("frozen",    32'(frozen),    32'(m_frozen));
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (sb_q.size() == 0) chk("rd_valid_spurious", 32'(rd_valid), 32'd0);
      else begin
        e = sb_q.pop_front();
        chk($sformatf("rd_data ch%0d sel%0d", e.ch, e.sel), rd_data, e.v);
      end
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk($sformatf("rd_valid_missing ch%0d sel%0d", e.ch, e.sel), 32'(rd_valid), 32'd1);
    end
  end

  task automatic drive(logic [NUM_CH-1:0] s, logic [NUM_CH-1:0] r,
                       logic [NUM_CH-1:0] d, logic [NUM_CH-1:0] c);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c;
  endtask

  task automatic idle();
    drive('0, '0, '0, '1);
  endtask

  task automatic drive_random();
    logic [NUM_CH-1:0] s, r, d, c;
    for (int k = 0; k < NUM_CH; k++) begin
      s[k] = ($urandom_range(0, 1) == 1);
      r[k] = ($urandom_range(0, 9) < 7);
      d[k] = ($urandom_range(0, 9) < 4);
      c[k] = ($urandom_range(0, 4) != 0);
    end
    drive(s, r, d, c);
  endtask

  task automatic read(int ch, int sel);
    rd_ch = CH_W'(ch); rd_sel = 3'(sel); rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic dump();
    for (int ch = 0; ch < 8; ch++)
      for (int sel = 0; sel < 8; sel++) read(ch, sel);
  endtask

  initial begin
    reset = 1'b1; finish = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
    idle();
    repeat (3) step();
    reset = 1'b0;
    dump();

    // ch0 combinational block: start/ready/done together for three cycles
    drive(5'b00001, 5'b00001, 5'b00001, '1);
    repeat (3) step();
    idle();
    read(0, 0); read(0, 1); read(0, 3); read(0, 4); read(0, 5);

    // ch1 pipelined: accepts every 2 cycles, completions 7 cycles later
    rd_ch = 3'd1; rd_sel = 3'd6;
    for (int k = 0; k < 12; k++) begin
      logic [NUM_CH-1:0] s, d;
      s = (k == 0 || k == 2 || k == 4) ? 5'b00010 : 5'b00000;
      d = (k == 7 || k == 9 || k == 11) ? 5'b00010 : 5'b00000;
      drive(s, s, d, '1);
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    idle();
    for (int sel = 0; sel < 8; sel++) read(1, sel);

    // ch3 orphan done
    drive('0, '0, 5'b01000, '1);
    step();
    idle();
    read(3, 7); read(3, 1); read(3, 2);

    // ch2 overrun then hang
    drive(5'b00100, 5'b00100, '0, '1);
    repeat (5) step();
    idle();
    read(2, 0); read(2, 6); read(2, 7);
    repeat (HANG_TO + 4) step();
    read(2, 7);
    dump();

    // random traffic with random readout
    repeat (400) begin
      drive_random();
      rd_ch = CH_W'($urandom_range(0, 7));
      rd_sel = 3'($urandom_range(0, 7));
      rd_en = ($urandom_range(0, 1) == 1);
      step();
    end
    rd_en = 1'b0;
    idle();
    dump();

    // finish mid-run: traffic continues but statistics freeze
    drive_random();
    step();
    finish = 1'b1;
    drive(5'b00001, 5'b00001, 5'b00001, '1);
    repeat (2) step();
    finish = 1'b0;
    repeat (40) begin
      drive_random();
      rd_ch = CH_W'($urandom_range(0, 7));
      rd_sel = 3'($urandom_range(0, 7));
      rd_en = ($urandom_range(0, 1) == 1);
      step();
    end
    rd_en = 1'b0;
    idle();
    dump();

    // reset with two outstanding starts on ch1
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(5'b00010, 5'b00010, '0, '1);
    repeat (2) step();
    idle();
    read(1, 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    read(1, 6); read(1, 0); read(1, 7);
    dump();

    repeat (2) step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
Name: ap_ctrl_perf_monitor

Overview:
- Multi-channel, parametrised successor to the single-module ap_ctrl status monitor.
- Passively observes NUM_CH ap_ctrl_hs handshake groups (ap_start/ap_ready/ap_done/ap_continue).
- Measures per-channel transaction count, latency (min/max/sum) and initiation interval (min/max).
- Detects pipelined overrun, orphan done and hangs; results read back through a registered readout port. Sits in the sim/verification top beside the CSV dumpers, and is synthesizable for on-chip profiling.

Parameters:
NUM_CH, 4, number of monitored ap_ctrl channels (1..16)
CNT_W, 32, width of cycle timestamp and all statistic counters
MAX_OUT, 4, per-channel depth of outstanding-start timestamp FIFO (power of 2, >=2)
HANG_TO, 1024, cycles with outstanding work and no ap_done before hang flags

Ports:
clock  in  1  monitor clock
reset  in  1  synchronous, active-high reset
finish  in  1  end of simulation/run; freezes all statistics
ap_start  in  NUM_CH  per-channel ap_start
ap_ready  in  NUM_CH  per-channel ap_ready
ap_done  in  NUM_CH  per-channel ap_done
ap_continue  in  NUM_CH  per-channel ap_continue (tie 1 for blocks without it)
rd_ch  in  $clog2(NUM_CH) (min 1)  channel select for readout
rd_sel  in  3  statistic select: 0 count, 1 lat_min, 2 lat_max, 3 lat_sum, 4 ii_min, 5 ii_max, 6 outstanding, 7 flags {hang,underflow,overflow}
rd_en  in  1  readout request
rd_data  out  CNT_W  selected statistic
rd_valid  out  1  rd_data valid
overflow  out  NUM_CH  sticky: accept while FIFO full
underflow  out  NUM_CH  sticky: completion with no outstanding start
hang  out  NUM_CH  sticky: hang timeout hit
all_idle  out  1  every channel has zero outstanding
frozen  out  1  statistics frozen by finish

Behaviour:
- Reset (sync, clock edge with reset=1): timestamp=0, all counts/sums/maxima=0, minima=all-ones, FIFOs empty, flags 0, rd_valid=0, rd_data=0, frozen=0, all_idle=1. Reset mid-transaction discards outstanding entries; no partial statistics kept.
- Timestamp: free-running CNT_W counter, +1 per cycle, wraps; latency/II computed modulo 2^CNT_W.
- Accept event ch: ap_start&ap_ready. Completion event ch: ap_done&ap_continue. Both evaluated per cycle.
- Accept: push current timestamp; count+1; if a previous accept exists, II = ts - last_accept_ts, update ii_min/ii_max; store last_accept_ts. First accept updates no II.
- Completion with FIFO non-empty: pop head, lat = ts - head, update lat_min/lat_max, lat_sum += lat.
- Simultaneous accept+completion, FIFO empty: bypass, lat=0 (combinational blocks), FIFO stays empty, no underflow.
- Simultaneous accept+completion, FIFO non-empty: pop head and push new in same cycle; occupancy unchanged.
- Accept with FIFO full (and no same-cycle pop): overflow set, timestamp dropped, count still increments.
- Completion with FIFO empty and no same-cycle accept: underflow set, no latency update.
- All counters/sums saturate at all-ones; no wrap.
- Hang: per-channel idle counter resets on completion or when outstanding=0; increments otherwise; reaching HANG_TO sets hang (sticky until reset).
- finish: on first clock with finish=1, frozen<=1 (sticky until reset); from that edge on no statistic, FIFO or flag changes; timestamp keeps running; readout keeps working.
- Readout: rd_en sampled at clock edge -> rd_data/rd_valid next cycle (1-cycle latency); rd_valid=0 when rd_en=0, rd_data holds. rd_ch >= NUM_CH returns 0 with rd_valid=1. Values narrower than CNT_W zero-extended.
- all_idle: registered, 1 iff all channel occupancies zero after current-cycle updates.

Test Plan:
- Combinational block, ch0: start=ready=done=1 at cycles 10,11,12 -> count=3, lat_min=lat_max=lat_sum=0, ii_min=ii_max=1, no flags, all_idle=1.
- Pipelined ch1: accepts at ts 5,7,9, dones at 12,14,16 -> outstanding peaks 3, lat_min=lat_max=7, lat_sum=21, ii_min=ii_max=2.
- Overrun ch2, MAX_OUT=4: 5 accepts no done -> overflow[2]=1, count=5, outstanding=4; HANG_TO cycles later hang[2]=1; all_idle=0.
- Orphan ap_done on ch3 with empty FIFO -> underflow[3]=1, lat stats stay min=all-ones/max=0; rd_sel=7 reads 3'b010.
- finish asserted mid-run then further accept/done on ch0 -> frozen=1, count/lat unchanged on readback, rd_valid 1 cycle after rd_en.
- Reset asserted with ch1 holding 2 outstanding -> next cycle outstanding=0, count=0, flags cleared, all_idle=1.
